// File: rtl/uart_tx_engine.sv
// 16550-style UART transmit path: TX FIFO / holding register, 16x baud
// prescaler, frame serialiser and THRE/TEMT status for LSR.
module uart_tx_engine #(
    parameter int FIFO_DEPTH    = 16,
    parameter int DIVISOR_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_fifo_enable,
    input  logic                          i_tx_fifo_reset,
    input  logic [1:0]                    i_wls,
    input  logic                          i_stb,
    input  logic                          i_pen,
    input  logic                          i_eps,
    input  logic                          i_stick_parity,
    input  logic                          i_set_break,
    input  logic [DIVISOR_WIDTH-1:0]      i_divisor,
    input  logic                          i_thr_valid,
    input  logic [DATA_WIDTH-1:0]         i_thr_data,
    output logic                          o_thr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_thre,
    output logic                          o_temt,
    output logic                          o_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     fifo_en_q;
    logic [DIVISOR_WIDTH-1:0] presc_q, presc_d;
    logic [4:0]               tick_cnt_q, tick_cnt_d;
    logic [4:0]               stop_last_q, stop_last_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d, data_last_q, data_last_d;
    logic                     pen_q, pen_d, par_q, par_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic                     tx_q, tx_d;

    logic                     full, flush, push, pop, can_load, tick, tick_last;
    logic [DATA_WIDTH-1:0]    rd_data, char_mask;

    // Bits that belong to the character at the current word length.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
            assign char_mask[gi] = (32'(i_wls) + 32'd5) > 32'(gi);
        end
    endgenerate

    assign rd_data   = mem_q[rd_ptr_q];
    assign full      = fifo_en_q ? (count_q == CW'(FIFO_DEPTH)) : (count_q != '0);
    assign flush     = i_tx_fifo_reset || (i_fifo_enable != fifo_en_q);
    assign push      = i_thr_valid && !full && !flush;
    assign can_load  = (count_q != '0) && !flush;
    assign tick      = (state_q != S_IDLE) && (i_divisor != '0) && (presc_q == '0);
    assign tick_last = tick && (tick_cnt_q == ((state_q == S_STOP) ? stop_last_q : 5'd15));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        data_last_d = data_last_q;
        stop_last_d = stop_last_q;
        pen_d       = pen_q;
        par_d       = par_q;
        shift_d     = shift_q;
        pop         = 1'b0;
        tx_d        = 1'b1;

        // A zero divisor freezes the prescaler and therefore the whole frame.
        if (state_q != S_IDLE && i_divisor != '0)
            presc_d = (presc_q == '0) ? i_divisor - DIVISOR_WIDTH'(1) : presc_q - DIVISOR_WIDTH'(1);
        if (tick)
            tick_cnt_d = tick_last ? 5'd0 : tick_cnt_q + 5'd1;

        case (state_q)
            S_IDLE:   pop = can_load;
            S_START:  if (tick_last) begin
                          state_d   = S_DATA;
                          bit_cnt_d = '0;
                      end
            S_DATA:   if (tick_last) begin
                          shift_d = shift_q >> 1;
                          if (bit_cnt_q == data_last_q)
                              state_d = pen_q ? S_PARITY : S_STOP;
                          else
                              bit_cnt_d = bit_cnt_q + 3'd1;
                      end
            S_PARITY: if (tick_last) state_d = S_STOP;
            S_STOP:   if (tick_last) begin
                          if (can_load) pop = 1'b1;
                          else          state_d = S_IDLE;
                      end
            default:  state_d = S_IDLE;
        endcase

        // Loading a character latches its line settings and restarts bit timing.
        if (pop) begin
            state_d     = S_START;
            shift_d     = rd_data;
            data_last_d = 3'd4 + {1'b0, i_wls};
            stop_last_d = !i_stb ? 5'd15 : ((i_wls == 2'd0) ? 5'd23 : 5'd31);
            pen_d       = i_pen;
            par_d       = i_stick_parity ? !i_eps
                        : (i_eps ? ^(rd_data & char_mask) : ~^(rd_data & char_mask));
            tick_cnt_d  = '0;
            presc_d     = (i_divisor == '0) ? '0 : i_divisor - DIVISOR_WIDTH'(1);
        end
        if (state_d == S_IDLE) begin
            presc_d    = '0;
            tick_cnt_d = '0;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fifo_en_q   <= i_fifo_enable;
            presc_q     <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            data_last_q <= 3'd7;
            stop_last_q <= 5'd15;
            pen_q       <= 1'b0;
            par_q       <= 1'b0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_en_q   <= i_fifo_enable;
            presc_q     <= presc_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_last_q <= data_last_d;
            stop_last_q <= stop_last_d;
            pen_q       <= pen_d;
            par_q       <= par_d;
            shift_q     <= shift_d;
            tx_q        <= i_set_break ? 1'b0 : tx_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_thr_data;
    end

    assign o_thr_ready  = !full;
    assign o_fifo_count = count_q;
    assign o_thre       = (count_q == '0);
    assign o_temt       = (count_q == '0) && (state_q == S_IDLE);
    assign o_tx         = tx_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: expected line waveforms are built from frame rules
// (start, data LSB first, parity, stop) and compared cycle by cycle.
module tb_uart_tx_engine;
    logic        clk = 1'b0;
    logic        i_rst, i_fifo_enable, i_tx_fifo_reset;
    logic [1:0]  i_wls;
    logic        i_stb, i_pen, i_eps, i_stick_parity, i_set_break;
    logic [15:0] i_divisor;
    logic        i_thr_valid;
    logic [7:0]  i_thr_data;
    logic        o_thr_ready, o_thre, o_temt, o_tx;
    logic [4:0]  o_fifo_count;

    int checks = 0;
    int passes = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_engine #(.FIFO_DEPTH(16), .DIVISOR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_fifo_enable(i_fifo_enable),
        .i_tx_fifo_reset(i_tx_fifo_reset), .i_wls(i_wls), .i_stb(i_stb),
        .i_pen(i_pen), .i_eps(i_eps), .i_stick_parity(i_stick_parity),
        .i_set_break(i_set_break), .i_divisor(i_divisor),
        .i_thr_valid(i_thr_valid), .i_thr_data(i_thr_data),
        .o_thr_ready(o_thr_ready), .o_fifo_count(o_fifo_count),
        .o_thre(o_thre), .o_temt(o_temt), .o_tx(o_tx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One entry per 16x tick of the expected line level.
    function automatic void build_frame(input logic [7:0] d, input logic [1:0] wls,
                                        input logic stb, input logic pen,
                                        input logic eps, input logic stick);
        int n;
        bit x;
        bit p;
        int stop_ticks;
        n = 5 + int'(wls);
        x = 1'b0;
        exp_q.delete();
        repeat (16) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            repeat (16) exp_q.push_back(d[i]);
            x = x ^ d[i];
        end
        if (pen) begin
            p = stick ? !eps : (eps ? x : !x);
            repeat (16) exp_q.push_back(p);
        end
        stop_ticks = !stb ? 16 : ((wls == 2'd0) ? 24 : 32);
        repeat (stop_ticks) exp_q.push_back(1'b1);
    endfunction

    // Sends one character into an idle block; break and zero-divisor windows
    // are given as sample indices counted from the first start-bit sample.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic [1:0] wls,
                              input logic stb, input logic pen, input logic eps,
                              input logic stick, input int div,
                              input int bs, input int be, input int fs, input int fe);
        int total, c, k, errs, temt_errs;
        bit brk_prev, e;
        build_frame(d, wls, stb, pen, eps, stick);
        total = exp_q.size() * div;
        i_wls = wls; i_stb = stb; i_pen = pen; i_eps = eps; i_stick_parity = stick;
        i_divisor = 16'(div); i_thr_data = d; i_thr_valid = 1'b1;
        @(negedge clk);
        i_thr_valid = 1'b0;
        chk({tag, "_tx_after_accept"}, 32'(o_tx), 32'd1);
        chk({tag, "_count_after_accept"}, 32'(o_fifo_count), 32'd1);
        c = 0; k = 0; errs = 0; temt_errs = 0; brk_prev = 1'b0;
        while (c < total && k < total + 200) begin
            @(negedge clk);
            e = brk_prev ? 1'b0 : exp_q[c / div];
            if (o_tx !== e) errs++;
            if (o_temt !== 1'b0) temt_errs++;
            brk_prev = (k + 1 >= bs) && (k + 1 < be);
            i_set_break = brk_prev;
            i_divisor = ((k + 1 >= fs) && (k + 1 < fe)) ? 16'd0 : 16'(div);
            if (i_divisor != 16'd0) c++;
            k++;
        end
        i_set_break = 1'b0;
        i_divisor = 16'(div);
        chk({tag, "_bits_wrong"}, 32'(errs), 32'd0);
        chk({tag, "_temt_early"}, 32'(temt_errs), 32'd0);
        @(negedge clk);
        chk({tag, "_tx_end"}, 32'(o_tx), 32'd1);
        chk({tag, "_temt_end"}, 32'(o_temt), 32'd1);
        $display("frame %s data=%02h wls=%0d stb=%0d pen=%0d eps=%0d stick=%0d div=%0d samples=%0d",
                 tag, d, wls, stb, pen, eps, stick, div, k);
    endtask

    task automatic wait_temt(input string tag, input int budget);
        int n;
        n = 0;
        while (o_temt !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_temt_reached"}, 32'(o_temt), 32'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_temt !== 1'b1) bad++;
        end
        chk({tag, "_quiet"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int acc, falls, hi_run, gap_bad, blocked;
        bit prev_tx, prev_thre, thre_seen, done;
        logic [7:0] rd;

        i_rst = 1'b1; i_fifo_enable = 1'b1; i_tx_fifo_reset = 1'b0;
        i_wls = 2'd3; i_stb = 1'b0; i_pen = 1'b0; i_eps = 1'b0; i_stick_parity = 1'b0;
        i_set_break = 1'b0; i_divisor = 16'd1; i_thr_valid = 1'b0; i_thr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_count", 32'(o_fifo_count), 32'd0);
        chk("rst_thre", 32'(o_thre), 32'd1);
        chk("rst_temt", 32'(o_temt), 32'd1);
        chk("rst_ready", 32'(o_thr_ready), 32'd1);
        i_rst = 1'b0;
        @(negedge clk);

        send_frame("8n1_55", 8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0);
        send_frame("7e1_a5", 8'hA5, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 0);
        send_frame("7s1_a5", 8'hA5, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 0, 0, 0);
        send_frame("5n15_1f", 8'h1F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            send_frame($sformatf("rnd%0d", r), 8'($urandom), 2'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(1, 3)), 0, 0, 0, 0);
        end
        send_frame("break", 8'($urandom), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 40, 70, 0, 0);
        send_frame("div0", 8'($urandom), 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0, 50, 80);

        // FIFO mode: 20 write attempts while the first frame crawls at divisor 100.
        i_wls = 2'd3; i_stb = 1'b0; i_pen = 1'b0; i_stick_parity = 1'b0;
        i_divisor = 16'd100; i_thr_data = 8'hFF; i_thr_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_thr_ready) acc++;
            @(negedge clk);
        end
        i_thr_valid = 1'b0;
        $display("fifo writes attempted=20 accepted=%0d count=%0d", acc, o_fifo_count);
        chk("fifo_accepted", 32'(acc), 32'd17);
        chk("fifo_ready_full", 32'(o_thr_ready), 32'd0);
        chk("fifo_count_full", 32'(o_fifo_count), 32'd16);
        i_divisor = 16'd1;
        falls = 1; hi_run = 0; gap_bad = 0; thre_seen = 1'b0; done = 1'b0;
        prev_tx = o_tx; prev_thre = o_thre;
        for (int n = 0; n < 6000 && !done; n++) begin
            @(negedge clk);
            if (prev_tx && !o_tx) begin
                falls++;
                if (falls >= 3 && hi_run != 144) gap_bad++;
                hi_run = 0;
            end
            if (o_tx) hi_run++;
            if (!prev_thre && o_thre) begin
                thre_seen = 1'b1;
                chk("fifo_thre_at_17th", 32'(falls), 32'd17);
                chk("fifo_thre_tx_fall", 32'({prev_tx, o_tx}), 32'd2);
            end
            prev_tx = o_tx; prev_thre = o_thre; done = o_temt;
        end
        $display("fifo drain frames=%0d gaps_bad=%0d", falls, gap_bad);
        chk("fifo_drained", 32'(done), 32'd1);
        chk("fifo_frames", 32'(falls), 32'd17);
        chk("fifo_back_to_back", 32'(gap_bad), 32'd0);
        chk("fifo_thre_seen", 32'(thre_seen), 32'd1);

        // TX FIFO reset pulse flushes queued bytes and a simultaneous write.
        i_divisor = 16'd0; i_thr_data = 8'($urandom); i_thr_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_pre_count", 32'(o_fifo_count), 32'd2);
        i_tx_fifo_reset = 1'b1;
        @(negedge clk);
        i_tx_fifo_reset = 1'b0; i_thr_valid = 1'b0;
        $display("fifo reset pulse count=%0d tx=%0d", o_fifo_count, o_tx);
        chk("flush_count", 32'(o_fifo_count), 32'd0);
        chk("flush_temt_busy", 32'(o_temt), 32'd0);
        chk("flush_tx_stalled", 32'(o_tx), 32'd0);
        i_divisor = 16'd1;
        wait_temt("flush", 300);
        quiet("flush", 30);

        // Holding-register mode.
        i_fifo_enable = 1'b0;
        @(negedge clk);
        i_thr_data = 8'($urandom); i_thr_valid = 1'b1;
        @(negedge clk);
        i_thr_valid = 1'b0;
        chk("nf_count_a", 32'(o_fifo_count), 32'd1);
        chk("nf_ready_a", 32'(o_thr_ready), 32'd0);
        @(negedge clk);
        chk("nf_ready_after_load", 32'(o_thr_ready), 32'd1);
        rd = 8'($urandom);
        i_thr_data = rd; i_thr_valid = 1'b1;
        @(negedge clk);
        chk("nf_count_b", 32'(o_fifo_count), 32'd1);
        blocked = 0;
        i_thr_data = ~rd;
        repeat (5) begin
            if (o_thr_ready !== 1'b0 || o_fifo_count !== 5'd1) blocked++;
            @(negedge clk);
        end
        i_thr_valid = 1'b0;
        $display("non-fifo third write blocked cycles with error=%0d", blocked);
        chk("nf_third_blocked", 32'(blocked), 32'd0);
        i_fifo_enable = 1'b1;
        @(negedge clk);
        chk("nf_toggle_count", 32'(o_fifo_count), 32'd0);
        chk("nf_toggle_thre", 32'(o_thre), 32'd1);
        chk("nf_toggle_temt", 32'(o_temt), 32'd0);
        wait_temt("nf", 300);
        quiet("nf", 40);

        // Reset in the middle of a frame with a byte still queued.
        i_thr_data = 8'h00; i_thr_valid = 1'b1;
        @(negedge clk);
        i_thr_data = 8'($urandom);
        @(negedge clk);
        i_thr_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_pre_count", 32'(o_fifo_count), 32'd1);
        chk("mid_pre_tx", 32'(o_tx), 32'd0);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        $display("mid-frame reset tx=%0d count=%0d", o_tx, o_fifo_count);
        chk("mid_rst_tx", 32'(o_tx), 32'd1);
        chk("mid_rst_count", 32'(o_fifo_count), 32'd0);
        chk("mid_rst_thre", 32'(o_thre), 32'd1);
        chk("mid_rst_temt", 32'(o_temt), 32'd1);
        chk("mid_rst_ready", 32'(o_thr_ready), 32'd1);
        quiet("mid_rst", 20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Parametrised 16550-compatible UART transmit path, successor to the fixed 8-bit THR/LCR/FCR/DLL/DLM register set.
- Driven directly by CSR field outputs (LCR, FCR, divisor latch) and the THR write strobe.
- Contains a TX FIFO of configurable depth, a 16x baud prescaler with configurable divisor width, a frame-serialiser FSM, and THRE/TEMT status generation for LSR.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries in FIFO mode; power of two, >=2.
- DIVISOR_WIDTH, 16, width of the baud divisor ({DLM,DLL} = 16).
- DATA_WIDTH, 8, THR data width; maximum character length.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; synchronous, active-high
- i_fifo_enable  input  1  FCR.FIFOEN; 0 = single holding register
- i_tx_fifo_reset  input  1  one-cycle pulse; flushes TX FIFO
- i_wls  input  2  LCR.WLS; character length = 5+i_wls bits
- i_stb  input  1  LCR.STB; 0 = 1 stop bit; 1 = 2 stop bits (1.5 when i_wls=0)
- i_pen  input  1  LCR.PEN; parity enable
- i_eps  input  1  LCR.EPS; 1 = even parity
- i_stick_parity  input  1  LCR stick parity
- i_set_break  input  1  LCR.SET_BREAK
- i_divisor  input  DIVISOR_WIDTH  baud divisor
- i_thr_valid  input  1  THR write strobe
- i_thr_data  input  DATA_WIDTH  THR write data
- o_thr_ready  output  1  write accepted when valid&ready
- o_fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries
- o_thre  output  1  LSR.THRE; FIFO/holding register empty
- o_temt  output  1  LSR.TEMT; FIFO empty and serialiser idle
- o_tx  output  1  serial output, registered

Behaviour:
Reset:
- o_tx=1, FSM=IDLE, FIFO empty, o_fifo_count=0, o_thre=1, o_temt=1, o_thr_ready=1, prescaler cleared.

Storage and handshake:
- Capacity is FIFO_DEPTH when i_fifo_enable=1, else 1.
- o_thr_ready = !full (combinational from count).
- Write when full is not accepted, even if a pop happens in the same cycle.
- Write and pop in the same cycle on a non-full FIFO: count unchanged.
- Any change of i_fifo_enable, or i_tx_fifo_reset=1: FIFO flushed on that edge. A frame in flight completes. A simultaneous write is discarded.

Baud timing:
- Prescaler reloads with i_divisor-1 and emits a 16x tick on reaching 0.
- One bit = 16 ticks = 16*i_divisor cycles.
- i_divisor change takes effect at the next reload.
- i_divisor=0: no ticks; FSM stalls in its current state, o_tx holds.
- Prescaler and tick counter restart when a character is loaded.

FSM: IDLE -> START -> DATA -> PARITY -> STOP -> (START | IDLE).
- IDLE with FIFO non-empty: pop on that edge, latch data and i_wls/i_stb/i_pen/i_eps/i_stick_parity, go to START. o_tx=0 from the next cycle, so a write into an empty idle block shows o_tx low 2 edges after acceptance.
- START: 16 ticks at 0.
- DATA: 5+wls bits, LSB first, 16 ticks each. Upper data bits are ignored.
- PARITY: only if pen.
  - Stick parity: bit = !eps.
  - Otherwise even: XOR of sent bits; odd: its inverse.
- STOP: 16 ticks for stb=0, 24 ticks for stb=1 with wls=0, 32 ticks otherwise.
- End of STOP: FIFO non-empty -> pop and go to START on the same edge (no idle gap); else IDLE.

Status and break:
- o_thre=1 iff count=0.
- o_temt=1 iff count=0 and FSM=IDLE.
- i_set_break=1: o_tx forced 0 from the next cycle. FSM and timing continue unchanged; release restores normal o_tx next cycle.

Reset mid-frame:
- Frame aborted, o_tx=1 next cycle, all state at reset values.

Test Plan:
- 8N1, divisor=1, write 0x55: o_tx low 2 cycles after the accepting edge, then 16-cycle bits 0,1,0,1,0,1,0,1,0,1. o_temt returns to 1 exactly 160 cycles after the first low cycle.
- 7E1 (wls=2, pen=1, eps=1), divisor=1, write 0xA5: bits 0,1,0,1,0,0,1,0,1,1, parity bit=1, frame 160 cycles. Same with stick parity and eps=1: parity bit=0.
- 5-bit, stb=1, divisor=2, write 0x1F: start 32 cycles, five 1-bits, stop 48 cycles, total frame 240 cycles.
- FIFO mode, depth 16, divisor=100, 20 consecutive write attempts:
  - Exactly 17 accepted (16 in FIFO plus 1 in serialiser); o_thr_ready=0 thereafter.
  - Frames are back-to-back with no idle cycle; o_thre rises when the 17th character loads.
- Non-FIFO mode: 2 writes accepted, third blocked. Toggling i_fifo_enable mid-frame flushes the queued byte while the current frame completes; o_temt=1 after it.
- Mid-frame checks, one each: i_set_break -> o_tx=0 while asserted, o_temt timing unchanged. i_divisor=0 -> o_tx frozen, resumes on restore. i_rst -> o_tx=1 and o_fifo_count=0 next cycle.
